// File: rtl/lfsr_ser_seed_loader.sv
// Serial seed loader for the LFSR write/read chains: shifts a parallel seed in
// LSB first and captures the bits shifted out as the chain's previous contents.
module lfsr_ser_seed_loader #(
  parameter int ChainLen = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_chain_i,
  input  logic [ChainLen-1:0] req_data_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_chain_o,
  output logic [ChainLen-1:0] rsp_data_o,
  output logic                busy_o,
  output logic                w_ser_data_o,
  output logic                w_ser_en_o,
  input  logic                w_ser_data_i,
  output logic                r_ser_data_o,
  output logic                r_ser_en_o,
  input  logic                r_ser_data_i
);

  localparam int CntWidth = $clog2(ChainLen + 1);
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(ChainLen - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload are held stable until that edge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [ChainLen-1:0] shift_q, shift_d;
  logic [ChainLen-1:0] cap_q, cap_d;
  logic                chain_q, chain_d;
  logic                ser_in;
  logic                in_shift;

  assign ser_in   = chain_q ? r_ser_data_i : w_ser_data_i;
  assign in_shift = (state_q == SHIFT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      cap_q   <= '0;
      chain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      cap_q   <= cap_d;
      chain_q <= chain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    cap_d   = cap_q;
    chain_d = chain_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          shift_d = req_data_i;
          chain_d = req_chain_i;
          cnt_d   = '0;
          cap_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_q >> 1;
        // Inserting at the top means the bit sampled on cycle k lands at bit k
        // once all ChainLen bits have been captured.
        cap_d = {ser_in, cap_q[ChainLen-1:1]};
        if (cnt_q == LastCnt) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_data_o   = cap_q;
  assign rsp_chain_o  = chain_q;
  assign w_ser_en_o   = in_shift & ~chain_q;
  assign r_ser_en_o   = in_shift & chain_q;
  assign w_ser_data_o = in_shift & ~chain_q & shift_q[0];
  assign r_ser_data_o = in_shift & chain_q & shift_q[0];

endmodule
